cpu: RTL and testbench
======================

# cpu

8-bit accumulator-style datapath core: register A, register B, a 4-bit flags register, and a combinational ALU, all sharing one tri-stated 8-bit main bus. The core has no sequencer; every cycle is controlled by an externally supplied 32-bit control word. Its only external data path is `main_bus`, which it also shares with memory and I/O blocks.

## Interface
Parameters: none. Field positions and codes are fixed constants in `cpu_pkg`.

Ports:
- `clk`  in  1  system clock. All state updates on the rising edge.
- `rst`  in  1  reset, asynchronous, active-high. Clears A, B and flags.
- `iclk`  in  1  complementary phase of `clk`, driven as its inverse. It is the same clock, not a second domain. The block holds no state on it; the port exists only for pin compatibility.
- `control_word`  in  32  per-cycle control. Combinational effect; sampled at the `clk` rising edge.
- `main_bus`  inout  8  shared bus. Driven only when an output source is selected, otherwise `8'bz`.

## Operation
Control word fields; all unlisted bits are reserved and ignored:
- `[3:0]` OUT_SEL, the bus driver:
  - 0 drives A; 1 drives B; 2 drives ALU result; 3 drives `{4'b0, flags}`.
  - 4–15 leave the bus at Z. 0xF is the canonical "none".
- `[7:4]` ALU_OP:
  - 0x8 ADD: A+B.
  - 0x9 SUB: A+~B+1.
  - 0xA AND; 0xB OR.
  - 0xC PASS: result = A; canonical idle value.
  - Any other code gives result 0.
- `[11:8]` LOAD_SEL, the bus receiver:
  - 0 loads A; 1 loads B; 2 loads flags from `main_bus[3:0]`.
  - 3–15 load nothing. 0xF is the canonical "none".
- `[18]` FLAGS_EN: when 1, flags latch the ALU flag outputs at the `clk` edge.
  - If LOAD_SEL=2 in the same cycle, the bus load wins.

Flags, bit order `[0]` C, `[1]` Z, `[2]` N, `[3]` V:
- C: carry-out of the 9-bit sum. For SUB, C is 1 when there is no borrow (A ≥ B unsigned).
- Z: result == 0. N: result[7].
- V: signed overflow for ADD/SUB; 0 for the other ops.

Reference words (reserved bits shown as in the system's standard words):
- Idle: `0x3BF83FCF`.
- Load A from bus: `0x3BF830CF`. Load B from bus: `0x3BF831CF`.
- A ← A+B with flags: `0x3BE43082`.
- Drive A: `0x3BF83FC0`.

## Timing
- Reset: A=0x00, B=0x00, flags=0x0, immediately on `rst` high, regardless of `clk`.
  - `main_bus` stays controlled by OUT_SEL throughout; reset does not force Z.
- Bus drive, ALU result and flag outputs are combinational from `control_word` and the register state, with zero-cycle latency.
- Register writes happen at the `clk` rising edge with one-cycle latency. The new value is visible on the bus in the following cycle.
- Self-transfer: OUT_SEL and LOAD_SEL name the same register → the value is unchanged.
- ALU writeback: OUT_SEL=2 with LOAD_SEL=0 or 1 writes the pre-edge result. Operands update only after the edge, so there is no combinational loop through storage.
- Bus undriven: LOAD_SEL active while OUT_SEL selects nothing → the register captures whatever the external driver presents. An X/Z bus is the system's responsibility.
- `rst` asserted mid-cycle overrides any pending load.

## Structure
- `cpu_pkg` holds:
  - field bit ranges;
  - OUT_SEL, LOAD_SEL and ALU_OP code constants;
  - flag bit indices;
  - the canonical idle/none values.
- Sub-module `cpu_alu` is purely combinational: inputs a, b, op; outputs result[7:0], flags[3:0].
- The top level holds the three registers, the bus tri-state mux and the load decode.

## Test plan
1. Reset with idle word → A=B=flags=0, bus Z. Drive A (OUT_SEL=0) → bus 0x00.
2. External 24 → load A; external 18 → load B; word `0x3BE43082` → bus 42 during the cycle, A=42 after the edge. Drive A → bus 42; flags C=0, Z=0, N=0, V=0.
3. A=200, B=100, ADD with FLAGS_EN → A=44, C=1, V=0. A=100, B=100 → A=200, N=1, V=1.
4. A=5, B=5, SUB → A=0, Z=1, C=1. A=0, B=1, SUB → A=0xFF, C=0, N=1.
5. OUT_SEL=0xF and OUT_SEL=7 → bus Z. OUT_SEL=3 with flags 0b1010 → bus 0x0A.
6. `rst` pulsed between `clk` edges while a load of A is set up → A=0 immediately, and A remains 0 until the next `clk` rising edge after `rst` falls.

Source files
------------

// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module      : cpu_pkg
// Description : Control-word field layout, select/opcode constants and flag
//               bit indices for the 8-bit accumulator datapath core.
// Revision    : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam int c_field_w      = 4;
    localparam int c_out_sel_lsb  = 0;
    localparam int c_alu_op_lsb   = 4;
    localparam int c_load_sel_lsb = 8;
    localparam int c_flags_en_bit = 18;

    localparam logic [3:0] c_out_a     = 4'h0;
    localparam logic [3:0] c_out_b     = 4'h1;
    localparam logic [3:0] c_out_alu   = 4'h2;
    localparam logic [3:0] c_out_flags = 4'h3;
    localparam logic [3:0] c_out_none  = 4'hF;

    localparam logic [3:0] c_alu_add  = 4'h8;
    localparam logic [3:0] c_alu_sub  = 4'h9;
    localparam logic [3:0] c_alu_and  = 4'hA;
    localparam logic [3:0] c_alu_or   = 4'hB;
    localparam logic [3:0] c_alu_pass = 4'hC;

    localparam logic [3:0] c_load_a     = 4'h0;
    localparam logic [3:0] c_load_b     = 4'h1;
    localparam logic [3:0] c_load_flags = 4'h2;
    localparam logic [3:0] c_load_none  = 4'hF;

    localparam int c_flag_c = 0;
    localparam int c_flag_z = 1;
    localparam int c_flag_n = 2;
    localparam int c_flag_v = 3;

    localparam logic [31:0] c_word_idle = 32'h3BF8_3FCF;

    typedef struct packed {
        logic       flags_en;
        logic [3:0] load_sel;
        logic [3:0] alu_op;
        logic [3:0] out_sel;
    } ctrl_t;

    function automatic ctrl_t decode_ctrl(input logic [31:0] cw);
        ctrl_t d;
        d.out_sel  = cw[c_out_sel_lsb  +: c_field_w];
        d.alu_op   = cw[c_alu_op_lsb   +: c_field_w];
        d.load_sel = cw[c_load_sel_lsb +: c_field_w];
        d.flags_en = cw[c_flags_en_bit];
        return d;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cpu_alu.sv
`default_nettype none
// ============================================================================
// Module      : cpu_alu
// Description : Combinational 8-bit ALU with carry/zero/negative/overflow flags.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu_alu
    import cpu_pkg::*;
(
    input  logic [7:0] a,
    input  logic [7:0] b,
    input  logic [3:0] op,
    output logic [7:0] result,
    output logic [3:0] flags
);

    logic       w_is_sub;
    logic [7:0] w_b_eff;
    logic [8:0] w_sum;
    logic       w_carry;
    logic       w_ovf;

    // SUB shares the adder as A + ~B + 1, so carry-out means "no borrow".
    assign w_is_sub = (op == c_alu_sub);
    assign w_b_eff  = w_is_sub ? ~b : b;
    assign w_sum    = {1'b0, a} + {1'b0, w_b_eff} + {8'd0, w_is_sub};

    always_comb begin
        result  = 8'h00;
        w_carry = 1'b0;
        w_ovf   = 1'b0;
        case (op)
            c_alu_add, c_alu_sub: begin
                result  = w_sum[7:0];
                w_carry = w_sum[8];
                w_ovf   = (a[7] == w_b_eff[7]) && (w_sum[7] != a[7]);
            end
            c_alu_and:  result = a & b;
            c_alu_or:   result = a | b;
            c_alu_pass: result = a;
            default:    result = 8'h00;
        endcase
    end

    always_comb begin
        flags           = 4'h0;
        flags[c_flag_c] = w_carry;
        flags[c_flag_z] = (result == 8'h00);
        flags[c_flag_n] = result[7];
        flags[c_flag_v] = w_ovf;
    end

endmodule
`default_nettype wire

// File: rtl/cpu.sv
`default_nettype none
// ============================================================================
// Module      : cpu
// Description : Microcoded 8-bit accumulator datapath: A, B and flags registers
//               around a combinational ALU, all sharing one tri-stated bus.
// Revision    : 1.0 - initial release
// ============================================================================
module cpu
    import cpu_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        iclk,
    input  logic [31:0] control_word,
    inout  wire  [7:0]  main_bus
);

    ctrl_t      w_ctrl;
    logic [7:0] r_a;
    logic [7:0] r_b;
    logic [3:0] r_flags;
    logic [7:0] w_alu_result;
    logic [3:0] w_alu_flags;
    logic [7:0] w_bus_out;
    logic       w_bus_en;
    logic       w_unused_bits;

    assign w_ctrl = decode_ctrl(control_word);

    // Reserved control bits and the inverted clock phase carry no function.
    assign w_unused_bits = &{1'b0, control_word[31:19], control_word[17:12], iclk};

    cpu_alu u_alu (
        .a      (r_a),
        .b      (r_b),
        .op     (w_ctrl.alu_op),
        .result (w_alu_result),
        .flags  (w_alu_flags)
    );

    always_comb begin
        w_bus_en  = 1'b1;
        w_bus_out = 8'h00;
        case (w_ctrl.out_sel)
            c_out_a:     w_bus_out = r_a;
            c_out_b:     w_bus_out = r_b;
            c_out_alu:   w_bus_out = w_alu_result;
            c_out_flags: w_bus_out = {4'h0, r_flags};
            default:     w_bus_en  = 1'b0;
        endcase
    end

    assign main_bus = w_bus_en ? w_bus_out : 8'bz;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a     <= 8'h00;
            r_b     <= 8'h00;
            r_flags <= 4'h0;
        end else begin
            if (w_ctrl.load_sel == c_load_a) begin
                r_a <= main_bus;
            end
            if (w_ctrl.load_sel == c_load_b) begin
                r_b <= main_bus;
            end
            // An explicit bus load of flags takes priority over ALU flag capture.
            if (w_ctrl.load_sel == c_load_flags) begin
                r_flags <= main_bus[3:0];
            end else if (w_ctrl.flags_en) begin
                r_flags <= w_alu_flags;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_cpu.sv
`default_nettype none
// ============================================================================
// Module      : tb_cpu
// Description : Scoreboard bench for cpu: directed scenarios plus random
//               control words checked against an arithmetic reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_cpu;
    import cpu_pkg::*;

    localparam logic [31:0] c_w_load_a  = 32'h3BF8_30CF;
    localparam logic [31:0] c_w_load_b  = 32'h3BF8_31CF;
    localparam logic [31:0] c_w_add_f   = 32'h3BE4_3082;
    localparam logic [31:0] c_w_sub_f   = 32'h3BE4_3092;
    localparam logic [31:0] c_w_drv_a   = 32'h3BF8_3FC0;
    localparam logic [31:0] c_w_drv_b   = 32'h3BF8_3FC1;
    localparam logic [31:0] c_w_drv_f   = 32'h3BF8_3FC3;
    localparam logic [31:0] c_w_drv_7   = 32'h3BF8_3FC7;
    localparam logic [31:0] c_w_load_f  = 32'h3BF8_32CF;
    localparam logic [31:0] c_w_ldf_en  = 32'h3BFC_32CF;
    localparam logic [31:0] c_w_self_a  = 32'h3BF8_30C0;

    typedef struct {
        bit         chk;
        logic [7:0] exp;
        string      name;
    } exp_t;

    logic        clk;
    logic        iclk;
    logic        rst;
    logic [31:0] control_word;
    logic [7:0]  r_ext;
    logic        r_ext_en;
    wire  [7:0]  main_bus;

    exp_t        scoreboard[$];
    int          n_checks;
    int          n_fail;
    logic [7:0]  m_a;
    logic [7:0]  m_b;
    logic [3:0]  m_f;

    assign main_bus = r_ext_en ? r_ext : 8'bz;
    assign iclk     = ~clk;

    cpu dut (
        .clk          (clk),
        .rst          (rst),
        .iclk         (iclk),
        .control_word (control_word),
        .main_bus     (main_bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%02h expected 0x%02h at %0t", name, act, exp, $time);
        end
    endtask

    // Returns {V, N, Z, C, result[7:0]} computed with plain integer arithmetic.
    function automatic logic [11:0] ref_alu(input logic [7:0] a, input logic [7:0] b,
                                           input logic [3:0] op);
        int         ua = a;
        int         ub = b;
        int         sa = $signed(a);
        int         sb = $signed(b);
        int         u;
        int         s;
        logic [7:0] r;
        bit         c = 0;
        bit         v = 0;
        case (op)
            4'h8: begin
                u = ua + ub; s = sa + sb;
                r = u[7:0]; c = (u > 255); v = (s > 127) || (s < -128);
            end
            4'h9: begin
                u = ua - ub; s = sa - sb;
                r = u[7:0]; c = (ua >= ub); v = (s > 127) || (s < -128);
            end
            4'hA:    r = a & b;
            4'hB:    r = a | b;
            4'hC:    r = a;
            default: r = 8'h00;
        endcase
        return {v, r[7], (r == 8'h00), c, r};
    endfunction

    // One clock cycle: apply the word, queue the expected bus value, advance the model.
    task automatic step(input logic [31:0] cw, input logic [7:0] ext, input string name);
        logic [3:0]  os  = cw[3:0];
        logic [3:0]  ls  = cw[11:8];
        logic [11:0] alu = ref_alu(m_a, m_b, cw[7:4]);
        logic [7:0]  bus;
        control_word = cw;
        r_ext_en     = (os > 4'h3);
        r_ext        = ext;
        case (os)
            4'h0:    bus = m_a;
            4'h1:    bus = m_b;
            4'h2:    bus = alu[7:0];
            4'h3:    bus = {4'h0, m_f};
            default: bus = ext;
        endcase
        scoreboard.push_back('{1'b1, bus, name});
        if (ls == 4'h0) m_a = bus;
        if (ls == 4'h1) m_b = bus;
        if (ls == 4'h2) m_f = bus[3:0];
        else if (cw[18]) m_f = alu[11:8];
        @(posedge clk);
        #1;
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (scoreboard.size() > 0) begin
                e = scoreboard.pop_front();
                if (e.chk) check(e.name, main_bus, e.exp);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        logic [31:0] cw;
        logic [3:0]  os;
        logic [3:0]  ls;
        int          wait_cycles;
        n_checks     = 0;
        n_fail       = 0;
        m_a          = 8'h00;
        m_b          = 8'h00;
        m_f          = 4'h0;
        rst          = 1'b1;
        control_word = c_word_idle;
        r_ext_en     = 1'b1;
        r_ext        = 8'h00;
        repeat (3) @(posedge clk);
        #1;

        r_ext_en = 1'b0;
        control_word = c_w_drv_a; #1; check("reset_a", main_bus, 8'h00);
        control_word = c_w_drv_b; #1; check("reset_b", main_bus, 8'h00);
        control_word = c_w_drv_f; #1; check("reset_flags", main_bus, 8'h00);
        @(posedge clk); #1;
        rst = 1'b0;

        step(c_word_idle, 8'h00, "idle_undriven");
        step(c_w_drv_a,   8'h00, "drive_a_after_reset");

        step(c_w_load_a, 8'd24, "load_a_24");
        step(c_w_load_b, 8'd18, "load_b_18");
        step(c_w_add_f,  8'h00, "add_bus_42");
        step(c_w_drv_a,  8'h00, "a_is_42");
        step(c_w_drv_f,  8'h00, "flags_after_42");

        step(c_w_load_a, 8'd200, "load_a_200");
        step(c_w_load_b, 8'd100, "load_b_100");
        step(c_w_add_f,  8'h00,  "add_200_100");
        step(c_w_drv_a,  8'h00,  "a_is_44");
        step(c_w_drv_f,  8'h00,  "flags_carry");
        step(c_w_load_a, 8'd100, "load_a_100");
        step(c_w_add_f,  8'h00,  "add_100_100");
        step(c_w_drv_a,  8'h00,  "a_is_200");
        step(c_w_drv_f,  8'h00,  "flags_n_v");

        step(c_w_load_a, 8'd5,  "load_a_5");
        step(c_w_load_b, 8'd5,  "load_b_5");
        step(c_w_sub_f,  8'h00, "sub_5_5");
        step(c_w_drv_a,  8'h00, "a_is_0");
        step(c_w_drv_f,  8'h00, "flags_z_c");
        step(c_w_load_b, 8'd1,  "load_b_1");
        step(c_w_sub_f,  8'h00, "sub_0_1");
        step(c_w_drv_a,  8'h00, "a_is_ff");
        step(c_w_drv_f,  8'h00, "flags_borrow_n");

        step(c_word_idle, 8'h00, "out_none_z");
        step(c_w_drv_7,   8'h00, "out_7_z");
        step(c_w_load_f,  8'h0A, "load_flags_0a");
        step(c_w_drv_f,   8'h00, "flags_0a");
        step(c_w_ldf_en,  8'h05, "load_flags_priority");
        step(c_w_drv_f,   8'h00, "flags_bus_wins");

        // Asynchronous reset in the middle of a cycle with an A load pending.
        step(c_w_load_a, 8'h77, "load_a_77");
        control_word = c_w_self_a;
        r_ext_en     = 1'b0;
        scoreboard.push_back('{1'b0, 8'h00, "rst_cycle"});
        #1; check("pre_rst_a", main_bus, 8'h77);
        rst = 1'b1;
        #1; check("rst_async_a", main_bus, 8'h00);
        rst = 1'b0;
        #1; check("rst_hold_a", main_bus, 8'h00);
        m_a = 8'h00; m_b = 8'h00; m_f = 4'h0;
        @(posedge clk); #1;
        step(c_w_drv_a, 8'h00, "post_rst_a");
        step(c_w_drv_b, 8'h00, "post_rst_b");
        step(c_w_drv_f, 8'h00, "post_rst_flags");

        for (int i = 0; i < 300; i++) begin
            cw = $urandom;
            os = 4'($urandom_range(0, 7));
            if (os > 4'h3) os = ($urandom_range(0, 1) == 0) ? c_out_none : 4'($urandom_range(4, 15));
            ls = 4'($urandom_range(0, 4));
            if (ls > 4'h2) ls = ($urandom_range(0, 1) == 0) ? c_load_none : 4'($urandom_range(3, 15));
            cw[3:0]  = os;
            cw[11:8] = ls;
            if ($urandom_range(0, 3) != 0) cw[7:4] = 4'($urandom_range(8, 12));
            step(cw, 8'($urandom), "random");
        end

        step(c_w_drv_a, 8'h00, "final_a");
        step(c_w_drv_b, 8'h00, "final_b");
        step(c_w_drv_f, 8'h00, "final_flags");

        wait_cycles = 0;
        while (scoreboard.size() > 0 && wait_cycles < 5) begin
            @(posedge clk);
            wait_cycles++;
        end
        if (scoreboard.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d entries left, expected 0", scoreboard.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
